// File: rtl/dmem_responder.sv
// Multi-cycle data memory for the MEM stage: stalls the pipeline for a programmable
// latency, then acknowledges with a registered load result and a fault flag.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic           wr_q;
    logic           both_q;
    logic [31:0]    data_q;
    logic           ack_q;
    logic           err_q;

    logic [31:0]    mem_q [DEPTH_WORDS];

    logic           misaligned;
    logic           out_of_range;
    logic           addr_ok;
    logic [AW-1:0]  word_idx;
    logic           access_now;
    logic           mem_we;

    assign misaligned   = |addr_q[1:0];
    assign out_of_range = addr_q[31:2] >= 30'(DEPTH_WORDS);
    assign addr_ok      = !misaligned && !out_of_range;
    assign word_idx     = addr_q[AW+1:2];
    assign access_now   = (state_q == BUSY) && (cnt_q == '0);
    // A reset arriving in the last BUSY cycle must still suppress the store.
    assign mem_we       = start_i && access_now && wr_q && addr_ok;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[word_idx] <= wdata_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!start_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            both_q  <= 1'b0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (MemRead_i || MemWrite_i) begin
                        addr_q  <= addr_i;
                        wdata_q <= data_i;
                        wr_q    <= MemWrite_i;
                        both_q  <= MemRead_i && MemWrite_i;
                        cnt_q   <= CW'(LATENCY - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                        err_q   <= !addr_ok || both_q;
                        if (!wr_q) begin
                            data_q <= addr_ok ? mem_q[word_idx] : 32'h0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    // Requests still show the completing instruction here.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        stall_o = 1'b0;
        if (start_i) begin
            case (state_q)
                IDLE:    stall_o = MemRead_i || MemWrite_i;
                BUSY:    stall_o = 1'b1;
                default: stall_o = 1'b0;
            endcase
        end
    end

    assign data_o = data_q;
    assign ack_o  = ack_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, hand-written reset/back-to-back sequences,
// and randomized accesses checked against a word-array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic        MemRead_i = 1'b0;
    logic        MemWrite_i = 1'b0;
    logic [31:0] data_o;
    logic        stall_o;
    logic        ack_o;
    logic        err_o;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i     (clk),
        .start_i   (start_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .MemRead_i (MemRead_i),
        .MemWrite_i(MemWrite_i),
        .data_o    (data_o),
        .stall_o   (stall_o),
        .ack_o     (ack_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] last_load_m = '0;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        bit          exp_err;
        logic [31:0] exp_data;
        bit          chk_data;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference: word array, faults from address arithmetic, store wins when both strobes set.
    task automatic model_access(input bit rd, input bit wr, input logic [31:0] addr,
                                input logic [31:0] data, output bit exp_err,
                                output logic [31:0] exp_data);
        bit bad;
        bad     = (addr % 4 != 0) || ((addr / 4) >= 32'(DEPTH));
        exp_err = bad || (rd && wr);
        if (wr) begin
            if (!bad) mem_m[addr[9:2]] = data;
        end else begin
            last_load_m = bad ? 32'h0 : mem_m[addr[9:2]];
        end
        exp_data = last_load_m;
    endtask

    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [31:0] data, output logic [31:0] dout,
                             output bit err, output int lat, output int stalls);
        @(negedge clk);
        MemRead_i  = rd;
        MemWrite_i = wr;
        addr_i     = addr;
        data_i     = data;
        lat        = 0;
        stalls     = 0;
        #1;
        while (lat < 40) begin
            if (stall_o) stalls++;
            if (ack_o) break;
            @(negedge clk);
            lat++;
        end
        dout       = data_o;
        err        = err_o;
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
    endtask

    task automatic run_access(input string tag, input bit rd, input bit wr,
                              input logic [31:0] addr, input logic [31:0] data,
                              input bit exp_err, input logic [31:0] exp_data,
                              input bit chk_data);
        logic [31:0] dout;
        bit          err;
        int          lat;
        int          stalls;
        do_access(rd, wr, addr, data, dout, err, lat, stalls);
        $display("%s rd=%0d wr=%0d addr=0x%08h wdata=0x%08h -> data_o=0x%08h err=%0d lat=%0d stalls=%0d",
                 tag, rd, wr, addr, data, dout, err, lat, stalls);
        chk({tag, "_ack_latency"}, 32'(lat), 32'(LAT + 1));
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(LAT + 1));
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        if (chk_data) chk({tag, "_data"}, dout, exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          e_err;
        logic [31:0] e_data;
        int          lat;
        int          acks;
        int          first_ack;
        int          second_ack;

        tbl[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 32'h20,  32'hA5A5A5A5, 1'b0, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h13,  32'h0,        1'b1, 32'h0,        1'b1};
        tbl[4]  = '{1'b0, 1'b1, 32'h22,  32'h11111111, 1'b1, 32'h0,        1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'h20,  32'h0,        1'b0, 32'hA5A5A5A5, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 32'h0,   32'hCAFEF00D, 1'b0, 32'h0,        1'b0};
        tbl[7]  = '{1'b0, 1'b1, 32'h400, 32'h0BADBAD0, 1'b1, 32'h0,        1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'hCAFEF00D, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 32'h8,   32'h77777777, 1'b1, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 1'b0, 32'h8,   32'h0,        1'b0, 32'h77777777, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 32'h404, 32'h0,        1'b1, 32'h0,        1'b1};

        // Reset held with a pending load: outputs stay quiet.
        start_i   = 1'b0;
        MemRead_i = 1'b1;
        addr_i    = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_stall", {31'b0, stall_o}, 32'h0);
            chk("rst_ack", {31'b0, ack_o}, 32'h0);
            chk("rst_data", data_o, 32'h0);
        end
        start_i = 1'b1;
        #1;
        chk("rst_release_stall", {31'b0, stall_o}, 32'h1);
        lat = 0;
        while (lat < 40 && !ack_o) begin
            @(negedge clk);
            lat++;
        end
        $display("rst_release load addr=0x00000000 -> ack after %0d cycles", lat);
        chk("rst_release_latency", 32'(lat), 32'(LAT + 1));
        MemRead_i = 1'b0;

        for (int i = 0; i < 12; i++) begin
            model_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, e_err, e_data);
            run_access($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data,
                       tbl[i].exp_err, tbl[i].exp_data, tbl[i].chk_data);
        end

        for (int w = 0; w < 32; w++) begin
            logic [31:0] d;
            d = $urandom;
            model_access(1'b0, 1'b1, 32'(w * 4), d, e_err, e_data);
            run_access("init", 1'b0, 1'b1, 32'(w * 4), d, e_err, e_data, 1'b1);
        end

        // Reset in the 2nd BUSY cycle of a store aborts it.
        @(negedge clk);
        MemWrite_i = 1'b1;
        addr_i     = 32'h40;
        data_i     = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        start_i    = 1'b0;
        MemWrite_i = 1'b0;
        @(negedge clk);
        chk("abort_stall", {31'b0, stall_o}, 32'h0);
        chk("abort_ack", {31'b0, ack_o}, 32'h0);
        chk("abort_data", data_o, 32'h0);
        start_i     = 1'b1;
        last_load_m = 32'h0;
        acks = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (ack_o) acks++;
            if (stall_o) acks++;
        end
        $display("abort idle window: ack/stall events=%0d", acks);
        chk("abort_idle_quiet", 32'(acks), 32'h0);
        model_access(1'b1, 1'b0, 32'h40, 32'h0, e_err, e_data);
        run_access("abort_reload", 1'b1, 1'b0, 32'h40, 32'h0, e_err, e_data, 1'b1);

        // Back-to-back loads, request held across DONE.
        @(negedge clk);
        MemRead_i  = 1'b1;
        addr_i     = 32'h0;
        acks       = 0;
        first_ack  = -1;
        second_ack = -1;
        for (int n = 0; n < 3 * LAT + 10; n++) begin
            if (ack_o) begin
                acks++;
                if (acks == 1) begin
                    first_ack = n;
                    chk("b2b_first_data", data_o, mem_m[0]);
                    addr_i = 32'h4;
                end else if (acks == 2) begin
                    second_ack = n;
                    chk("b2b_second_data", data_o, mem_m[1]);
                    MemRead_i = 1'b0;
                end
            end
            @(negedge clk);
        end
        MemRead_i   = 1'b0;
        last_load_m = mem_m[1];
        $display("b2b loads 0x0/0x4: acks=%0d at cycles %0d,%0d", acks, first_ack, second_ack);
        chk("b2b_ack_count", 32'(acks), 32'h2);
        chk("b2b_ack_spacing", 32'(second_ack - first_ack), 32'(LAT + 2));

        for (int i = 0; i < 80; i++) begin
            int          kind;
            int          op;
            bit          rd;
            bit          wr;
            logic [31:0] a;
            logic [31:0] d;
            kind = $urandom_range(0, 9);
            op   = $urandom_range(0, 9);
            d    = $urandom;
            if (kind < 7)       a = 32'($urandom_range(0, 31) * 4);
            else if (kind == 7) a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
            else                a = 32'((DEPTH + $urandom_range(0, 1000)) * 4 + $urandom_range(0, 1) * 2);
            rd = (op < 5) || (op == 9);
            wr = (op >= 5);
            model_access(rd, wr, a, d, e_err, e_data);
            run_access($sformatf("rnd%0d", i), rd, wr, a, d, e_err, e_data, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
